score_accum: RTL and testbench

SCORE_ACCUM -- requirements
Module: score_accum

---
 rtl/baccarat_pkg.sv | 34 +++
 rtl/score_accum_card_value.sv | 24 ++
 rtl/score_accum.sv | 134 +++++++++++++
 tb/tb_score_accum.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared widths, card code constants, per-hand state encoding and the
// modular-add helper for the baccarat score accumulator.
package baccarat_pkg;

   localparam int unsigned CARD_W  = 4;
   localparam int unsigned SCORE_W = 4;
   localparam int unsigned CNT_W   = 2;

   localparam logic [CARD_W-1:0] CARD_ACE   = 4'd1;
   localparam logic [CARD_W-1:0] CARD_NINE  = 4'd9;
   localparam logic [CARD_W-1:0] CARD_TEN   = 4'd10;
   localparam logic [CARD_W-1:0] CARD_JACK  = 4'd11;
   localparam logic [CARD_W-1:0] CARD_QUEEN = 4'd12;
   localparam logic [CARD_W-1:0] CARD_KING  = 4'd13;

   typedef enum logic [1:0] {
      HAND_EMPTY   = 2'd0,
      HAND_PARTIAL = 2'd1,
      HAND_FULL    = 2'd2
   } hand_state_e;

   // Both operands are already below the modulus, so one conditional
   // subtraction is enough to bring the sum back into range.
   function automatic logic [SCORE_W-1:0] mod_reduce(
      input logic [SCORE_W:0] sum,
      input logic [SCORE_W:0] modulus
   );
      if (sum >= modulus) begin
         return SCORE_W'(sum - modulus);
      end
      return SCORE_W'(sum);
   endfunction

endpackage

// File: rtl/score_accum_card_value.sv
// Card code to baccarat point value; flags the codes that are not cards.
module card_value
   import baccarat_pkg::*;
(
   input  logic [CARD_W-1:0]  card,
   output logic [SCORE_W-1:0] value,
   output logic               illegal
);

   // Pips count face value, ten and court cards count zero, anything else is illegal.
   always_comb begin
      value   = '0;
      illegal = 1'b0;
      if (card >= CARD_ACE && card <= CARD_NINE) begin
         value = card;
      end else if (card == CARD_TEN  || card == CARD_JACK ||
                   card == CARD_QUEEN || card == CARD_KING) begin
         value = '0;
      end else begin
         illegal = 1'b1;
      end
   end

endmodule

// File: rtl/score_accum.sv
// Per-hand baccarat score/count accumulator with valid/ready card intake,
// natural and full detection, and a sticky error flag.
module score_accum
   import baccarat_pkg::*;
#(
   parameter  int unsigned NHANDS   = 2,
   parameter  int unsigned MAXCARDS = 3,
   parameter  int unsigned MODULUS  = 10,
   localparam int unsigned HSEL_W   = (NHANDS > 1) ? $clog2(NHANDS) : 1
) (
   input  logic                      slow_clock,
   input  logic                      resetb,
   input  logic                      clear,
   input  logic                      card_valid,
   output logic                      card_ready,
   input  logic [CARD_W-1:0]         card,
   input  logic [HSEL_W-1:0]         hand_sel,
   output logic [NHANDS*SCORE_W-1:0] score,
   output logic [NHANDS*CNT_W-1:0]   count,
   output logic [NHANDS-1:0]         natural,
   output logic [NHANDS-1:0]         full,
   output logic                      err
);

   logic [SCORE_W-1:0] r_score [NHANDS];
   logic [CNT_W-1:0]   r_count [NHANDS];
   hand_state_e        r_state [NHANDS];
   logic [NHANDS-1:0]  r_natural;
   logic [NHANDS-1:0]  r_full;
   logic               r_err;

   logic [SCORE_W-1:0] w_value;
   logic               w_illegal;
   logic               w_sel_ok;
   logic               w_sel_full;
   logic [SCORE_W-1:0] w_cur_score;
   logic [CNT_W-1:0]   w_cur_count;
   logic [SCORE_W:0]   w_sum;
   logic [SCORE_W-1:0] w_score_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic               w_hit_full;
   logic               w_hit_natural;
   logic               w_xfer;

   card_value u_card_value (
      .card    (card),
      .value   (w_value),
      .illegal (w_illegal)
   );

   // Look up the addressed hand; an out-of-range selector matches nothing.
   always_comb begin
      w_sel_ok    = 1'b0;
      w_sel_full  = 1'b0;
      w_cur_score = '0;
      w_cur_count = '0;
      for (int unsigned i = 0; i < NHANDS; i++) begin
         if (hand_sel == HSEL_W'(i)) begin
            w_sel_ok    = 1'b1;
            w_sel_full  = (r_state[i] == HAND_FULL);
            w_cur_score = r_score[i];
            w_cur_count = r_count[i];
         end
      end
   end

   // Handshake and next-state values for the addressed hand.
   always_comb begin
      card_ready    = !clear && w_sel_ok && !w_sel_full;
      w_xfer        = card_valid && card_ready;
      w_sum         = {1'b0, w_cur_score} + {1'b0, w_value};
      w_score_nxt   = mod_reduce(w_sum, (SCORE_W+1)'(MODULUS));
      w_count_nxt   = w_cur_count + CNT_W'(1);
      w_hit_full    = (w_count_nxt == CNT_W'(MAXCARDS));
      w_hit_natural = (w_count_nxt == CNT_W'(2)) &&
                      ((w_score_nxt == SCORE_W'(8)) || (w_score_nxt == SCORE_W'(9)));
   end

   // Hand state machines, registered flags and sticky error; clear mirrors reset.
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         for (int unsigned i = 0; i < NHANDS; i++) begin
            r_score[i] <= '0;
            r_count[i] <= '0;
            r_state[i] <= HAND_EMPTY;
         end
         r_natural <= '0;
         r_full    <= '0;
         r_err     <= 1'b0;
      end else if (clear) begin
         for (int unsigned i = 0; i < NHANDS; i++) begin
            r_score[i] <= '0;
            r_count[i] <= '0;
            r_state[i] <= HAND_EMPTY;
         end
         r_natural <= '0;
         r_full    <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_xfer) begin
            for (int unsigned i = 0; i < NHANDS; i++) begin
               if (hand_sel == HSEL_W'(i)) begin
                  r_score[i]   <= w_score_nxt;
                  r_count[i]   <= w_count_nxt;
                  r_natural[i] <= w_hit_natural;
                  r_full[i]    <= w_hit_full;
                  case (r_state[i])
                     HAND_EMPTY,
                     HAND_PARTIAL: r_state[i] <= w_hit_full ? HAND_FULL : HAND_PARTIAL;
                     default:      r_state[i] <= r_state[i];
                  endcase
               end
            end
         end
         if ((w_xfer && w_illegal) || (card_valid && !w_sel_ok)) begin
            r_err <= 1'b1;
         end
      end
   end

   // Pack per-hand registers onto the flat output buses.
   always_comb begin
      score = '0;
      count = '0;
      for (int unsigned i = 0; i < NHANDS; i++) begin
         score[i*SCORE_W +: SCORE_W] = r_score[i];
         count[i*CNT_W +: CNT_W]     = r_count[i];
      end
      natural = r_natural;
      full    = r_full;
      err     = r_err;
   end

endmodule

// File: tb/tb_score_accum.sv
// Directed self-checking bench for score_accum (default and 4-hand builds).
module tb_score_accum;

   logic clk;
   logic rst_n;

   logic       d2_clear, d2_valid, d2_ready, d2_sel, d2_err;
   logic [3:0] d2_card;
   logic [7:0] d2_score;
   logic [3:0] d2_count;
   logic [1:0] d2_natural, d2_full;

   logic        d4_clear, d4_valid, d4_ready, d4_err;
   logic [1:0]  d4_sel;
   logic [3:0]  d4_card;
   logic [15:0] d4_score;
   logic [7:0]  d4_count;
   logic [3:0]  d4_natural, d4_full;

   int tests_run    = 0;
   int tests_failed = 0;

   score_accum dut2 (
      .slow_clock (clk),
      .resetb     (rst_n),
      .clear      (d2_clear),
      .card_valid (d2_valid),
      .card_ready (d2_ready),
      .card       (d2_card),
      .hand_sel   (d2_sel),
      .score      (d2_score),
      .count      (d2_count),
      .natural    (d2_natural),
      .full       (d2_full),
      .err        (d2_err)
   );

   score_accum #(.NHANDS(4), .MAXCARDS(3), .MODULUS(10)) dut4 (
      .slow_clock (clk),
      .resetb     (rst_n),
      .clear      (d4_clear),
      .card_valid (d4_valid),
      .card_ready (d4_ready),
      .card       (d4_card),
      .hand_sel   (d4_sel),
      .score      (d4_score),
      .count      (d4_count),
      .natural    (d4_natural),
      .full       (d4_full),
      .err        (d4_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic send2(input logic [3:0] c, input logic h);
      @(negedge clk);
      d2_valid = 1'b1; d2_card = c; d2_sel = h;
      @(posedge clk); #1;
      d2_valid = 1'b0;
   endtask

   task automatic send4(input logic [3:0] c, input logic [1:0] h);
      @(negedge clk);
      d4_valid = 1'b1; d4_card = c; d4_sel = h;
      @(posedge clk); #1;
      d4_valid = 1'b0;
   endtask

   task automatic clear2();
      @(negedge clk);
      d2_clear = 1'b1;
      @(posedge clk); #1;
      d2_clear = 1'b0;
   endtask

   task automatic test_reset();
      tests_run++;
      if (d2_score !== 8'h00 || d2_count !== 4'h0) begin
         tests_failed++; $display("FAIL reset_sc score=%h count=%h exp 00/0", d2_score, d2_count);
      end
      tests_run++;
      if (d2_natural !== 2'b00 || d2_full !== 2'b00 || d2_err !== 1'b0) begin
         tests_failed++; $display("FAIL reset_flags nat=%b full=%b err=%b exp 00/00/0", d2_natural, d2_full, d2_err);
      end
      tests_run++;
      if (d2_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_ready got %b exp 1", d2_ready);
      end
      tests_run++;
      if (d4_score !== 16'h0 || d4_count !== 8'h0 || d4_err !== 1'b0) begin
         tests_failed++; $display("FAIL reset_wide score=%h count=%h err=%b exp 0", d4_score, d4_count, d4_err);
      end
   endtask

   task automatic test_basic();
      send2(4'd7, 1'b0);
      tests_run++;
      if (d2_score[3:0] !== 4'd7 || d2_count !== 4'b0001) begin
         tests_failed++; $display("FAIL basic_first score0=%0d count=%b exp 7/0001", d2_score[3:0], d2_count);
      end
      send2(4'd13, 1'b1);
      send2(4'd5, 1'b0);
      tests_run++;
      if (d2_score !== 8'h02) begin
         tests_failed++; $display("FAIL basic_score got %h exp 02", d2_score);
      end
      tests_run++;
      if (d2_count !== 4'b0110) begin
         tests_failed++; $display("FAIL basic_count got %b exp 0110", d2_count);
      end
      tests_run++;
      if (d2_err !== 1'b0 || d2_natural !== 2'b00) begin
         tests_failed++; $display("FAIL basic_flags err=%b nat=%b exp 0/00", d2_err, d2_natural);
      end
   endtask

   task automatic test_natural();
      clear2();
      send2(4'd4, 1'b1);
      tests_run++;
      if (d2_natural !== 2'b00) begin
         tests_failed++; $display("FAIL nat_one_card got %b exp 00", d2_natural);
      end
      send2(4'd5, 1'b1);
      tests_run++;
      if (d2_natural !== 2'b10 || d2_score[7:4] !== 4'd9) begin
         tests_failed++; $display("FAIL nat_set nat=%b score1=%0d exp 10/9", d2_natural, d2_score[7:4]);
      end
      send2(4'd9, 1'b1);
      tests_run++;
      if (d2_natural !== 2'b00 || d2_score[7:4] !== 4'd8) begin
         tests_failed++; $display("FAIL nat_third nat=%b score1=%0d exp 00/8", d2_natural, d2_score[7:4]);
      end
      tests_run++;
      if (d2_full !== 2'b10 || d2_count[3:2] !== 2'd3) begin
         tests_failed++; $display("FAIL nat_full full=%b count1=%0d exp 10/3", d2_full, d2_count[3:2]);
      end
   endtask

   task automatic test_full_hold();
      clear2();
      send2(4'd1, 1'b0);
      send2(4'd2, 1'b0);
      send2(4'd3, 1'b0);
      tests_run++;
      if (d2_full !== 2'b01 || d2_score[3:0] !== 4'd6 || d2_count[1:0] !== 2'd3) begin
         tests_failed++; $display("FAIL full_fill full=%b score0=%0d count0=%0d exp 01/6/3", d2_full, d2_score[3:0], d2_count[1:0]);
      end
      @(negedge clk);
      d2_valid = 1'b1; d2_card = 4'd9; d2_sel = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (d2_ready !== 1'b0 || d2_score[3:0] !== 4'd6 || d2_count[1:0] !== 2'd3 || d2_err !== 1'b0) begin
            tests_failed++; $display("FAIL full_hold cyc%0d ready=%b score0=%0d count0=%0d err=%b exp 0/6/3/0", k, d2_ready, d2_score[3:0], d2_count[1:0], d2_err);
         end
      end
      d2_valid = 1'b0;
   endtask

   task automatic test_illegal();
      clear2();
      send2(4'd3, 1'b0);
      send2(4'd0, 1'b0);
      tests_run++;
      if (d2_err !== 1'b1 || d2_count[1:0] !== 2'd2 || d2_score[3:0] !== 4'd3) begin
         tests_failed++; $display("FAIL illegal_0 err=%b count0=%0d score0=%0d exp 1/2/3", d2_err, d2_count[1:0], d2_score[3:0]);
      end
      send2(4'd14, 1'b0);
      tests_run++;
      if (d2_err !== 1'b1 || d2_count[1:0] !== 2'd3 || d2_score[3:0] !== 4'd3) begin
         tests_failed++; $display("FAIL illegal_14 err=%b count0=%0d score0=%0d exp 1/3/3", d2_err, d2_count[1:0], d2_score[3:0]);
      end
      clear2();
      tests_run++;
      if (d2_err !== 1'b0 || d2_count !== 4'h0 || d2_score !== 8'h00) begin
         tests_failed++; $display("FAIL illegal_clear err=%b count=%h score=%h exp 0/0/00", d2_err, d2_count, d2_score);
      end
   endtask

   task automatic test_clear_wins();
      send2(4'd2, 1'b0);
      send2(4'd15, 1'b1);
      @(negedge clk);
      d2_clear = 1'b1; d2_valid = 1'b1; d2_card = 4'd9; d2_sel = 1'b0;
      #1;
      tests_run++;
      if (d2_ready !== 1'b0) begin
         tests_failed++; $display("FAIL clrwin_ready got %b exp 0", d2_ready);
      end
      @(posedge clk); #1;
      d2_clear = 1'b0; d2_valid = 1'b0;
      tests_run++;
      if (d2_count !== 4'h0 || d2_score !== 8'h00 || d2_err !== 1'b0) begin
         tests_failed++; $display("FAIL clrwin_state count=%h score=%h err=%b exp 0/00/0", d2_count, d2_score, d2_err);
      end
   endtask

   task automatic test_back_to_back();
      clear2();
      @(negedge clk);
      d2_valid = 1'b1; d2_card = 4'd9; d2_sel = 1'b0;
      @(posedge clk); #1;
      d2_sel = 1'b1;
      @(posedge clk); #1;
      d2_sel = 1'b0;
      @(posedge clk); #1;
      d2_valid = 1'b0;
      tests_run++;
      if (d2_score !== 8'h98 || d2_count !== 4'b0110) begin
         tests_failed++; $display("FAIL b2b_sc score=%h count=%b exp 98/0110", d2_score, d2_count);
      end
      tests_run++;
      if (d2_natural !== 2'b01) begin
         tests_failed++; $display("FAIL b2b_nat got %b exp 01", d2_natural);
      end
   endtask

   task automatic test_async_reset();
      clear2();
      send2(4'd3, 1'b0);
      send2(4'd15, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (d2_score !== 8'h00 || d2_count !== 4'h0 || d2_err !== 1'b0 || d2_full !== 2'b00) begin
         tests_failed++; $display("FAIL async_rst score=%h count=%h err=%b full=%b exp 0", d2_score, d2_count, d2_err, d2_full);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send2(4'd6, 1'b1);
      tests_run++;
      if (d2_score !== 8'h60 || d2_count !== 4'b0100) begin
         tests_failed++; $display("FAIL async_after score=%h count=%b exp 60/0100", d2_score, d2_count);
      end
   endtask

   task automatic test_wide();
      send4(4'd7, 2'd2);
      send4(4'd13, 2'd3);
      send4(4'd5, 2'd2);
      tests_run++;
      if (d4_score !== 16'h0200) begin
         tests_failed++; $display("FAIL wide_score got %h exp 0200", d4_score);
      end
      tests_run++;
      if (d4_count !== 8'b0110_0000 || d4_err !== 1'b0) begin
         tests_failed++; $display("FAIL wide_count count=%b err=%b exp 01100000/0", d4_count, d4_err);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      d2_clear = 1'b0; d2_valid = 1'b0; d2_card = 4'd0; d2_sel = 1'b0;
      d4_clear = 1'b0; d4_valid = 1'b0; d4_card = 4'd0; d4_sel = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_basic();
      test_natural();
      test_full_hold();
      test_illegal();
      test_clear_wins();
      test_back_to_back();
      test_async_reset();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
